rr_arb_encoder: RTL

//  Round-robin arbiter sharing one downstream resource among N requesters.

---
 rtl/rr_arb_if.sv | 14 +
 rtl/rr_arb_encoder.sv | 124 ++++++++++++
 2 files changed

// File: rtl/rr_arb_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
interface rr_arb_if #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3
);
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             timeout_err;

  modport master (output req, input gnt, gnt_idx, gnt_valid, timeout_err);
  modport slave  (input req, output gnt, gnt_idx, gnt_valid, timeout_err);
endinterface

// File: rtl/rr_arb_encoder.sv
// Round-robin arbiter with registered one-hot grant and encoded index for mux steering.
// Optional forced-revoke timeout enabled by defining ARB_TIMEOUT_EN.
module rr_arb_encoder #(
  parameter int unsigned N        = 8,
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  rr_arb_if.slave   bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [N-1:0]     blk;

  logic [IDX_W-1:0] next_ptr_c;
  logic [IDX_W-1:0] start_c;
  logic [IDX_W-1:0] cand_c;
  logic [IDX_W-1:0] win_c;
  logic [N-1:0]     eligible_c;
  logic             owner_req_c;
  logic             revoke_c;
  logic             handoff_c;
  logic             found_c;

  if (IDX_W != $clog2(N) || N < 2 || N > 32 || HOLD_MAX < 1) begin : g_param_check
    $error("rr_arb_encoder: illegal parameterisation");
  end

  // Release/revoke bookkeeping: the current owner is always excluded from the search.
  always_comb begin
    owner_req_c = bus.req[bus.gnt_idx];
    next_ptr_c  = (bus.gnt_idx == IDX_W'(N - 1)) ? '0 : bus.gnt_idx + 1'b1;
    start_c     = (state == BUSY) ? next_ptr_c : ptr;
    eligible_c  = bus.req & ~blk & ~bus.gnt;
    handoff_c   = (state == BUSY) && (!owner_req_c || revoke_c);
  end

  // First eligible requester in rotating order starting at start_c.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    cand_c  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand_c = IDX_W'((32'(start_c) + i) % N);
      if (!found_c && eligible_c[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      bus.gnt       <= '0;
      bus.gnt_idx   <= '0;
      bus.gnt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found_c) begin
            state         <= BUSY;
            bus.gnt       <= N'(1) << win_c;
            bus.gnt_idx   <= win_c;
            bus.gnt_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (handoff_c) begin
            ptr <= next_ptr_c;
            if (found_c) begin
              bus.gnt       <= N'(1) << win_c;
              bus.gnt_idx   <= win_c;
              bus.gnt_valid <= 1'b1;
            end else begin
              state         <= IDLE;
              bus.gnt       <= '0;
              bus.gnt_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             grant_new_c;

  // Revoke on the edge that would start the (HOLD_MAX+1)-th held cycle.
  assign revoke_c    = (state == BUSY) && owner_req_c && (hold_cnt == CNT_W'(HOLD_MAX - 1));
  assign grant_new_c = found_c && ((state == IDLE) || handoff_c);

  // A revoked owner stays blocked until it lowers its request once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt        <= '0;
      blk             <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.timeout_err <= revoke_c;
      blk             <= (blk & bus.req) | (revoke_c ? (N'(1) << bus.gnt_idx) : '0);
      if (grant_new_c) begin
        hold_cnt <= '0;
      end else if (state == BUSY) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign revoke_c        = 1'b0;
  assign blk             = '0;
  assign bus.timeout_err = 1'b0;
`endif

endmodule
